// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte requesters.
// Round-robin grant, locked for the whole message (until req_last), paced by
// the UART's is_transmitting. A locked owner that stalls for LOCK_TIMEOUT idle
// cycles loses its lock.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_byte/...   per-lane valid/ready byte handshake, lane i at [8*i+7:8*i]
//   req_ready                one-hot combinational accept strobe
//   grant                    one-hot current lock owner, 0 when unlocked
//   uart_transmit/tx_byte    UART transmit pulse and held byte
//   uart_is_transmitting     UART frame-in-flight status
//   busy                     not IDLE or lock held
//   lock_abort               one-cycle pulse on lock timeout
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned LOCK_TIMEOUT = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_byte,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 uart_transmit,
    output logic [7:0]           uart_tx_byte,
    input  logic                 uart_is_transmitting,
    output logic                 busy,
    output logic                 lock_abort
);

    localparam int unsigned IDX_W = (NUM_REQ > 2) ? 2 : 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [CNT_W-1:0]   stall_cnt;
    logic               last_flag;
    logic               locked;

    logic               accept;
    logic [IDX_W-1:0]   accept_idx;
    logic               abort;
    logic               release_lock;
    logic               stall_inc;
    logic [NUM_REQ-1:0] ready_sel;

    // (base + k) mod NUM_REQ for k < NUM_REQ
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    assign locked = |grant;
    assign busy   = (state != IDLE) || locked;

    // Ready is forced low while reset is held so no lane sees a false accept.
    assign req_ready = ready_sel & {NUM_REQ{rst}};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, arbitration and accept/abort/release decisions
    always_comb begin
        state_d      = state;
        accept       = 1'b0;
        accept_idx   = '0;
        abort        = 1'b0;
        release_lock = 1'b0;
        stall_inc    = 1'b0;
        ready_sel    = '0;
        case (state)
            IDLE: begin
                if (locked) begin
                    if (req_valid[owner]) begin
                        // Accept wins over a timeout expiring in the same cycle.
                        if (!uart_is_transmitting) begin
                            accept     = 1'b1;
                            accept_idx = owner;
                        end
                    end else if (stall_cnt == STALL_MAX) begin
                        abort = 1'b1;
                    end else begin
                        stall_inc = 1'b1;
                    end
                end else if (!uart_is_transmitting) begin
                    for (int unsigned k = 0; k < NUM_REQ; k++) begin
                        if (!accept && req_valid[wrap_add(rr_ptr, k)]) begin
                            accept     = 1'b1;
                            accept_idx = wrap_add(rr_ptr, k);
                        end
                    end
                end
                if (accept) begin
                    ready_sel[accept_idx] = 1'b1;
                    state_d               = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_is_transmitting) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!uart_is_transmitting) begin
                    release_lock = last_flag;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs, lock ownership and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant         <= '0;
            owner         <= '0;
            rr_ptr        <= '0;
            stall_cnt     <= '0;
            uart_tx_byte  <= '0;
            last_flag     <= 1'b0;
            uart_transmit <= 1'b0;
            lock_abort    <= 1'b0;
        end else begin
            uart_transmit <= accept;
            lock_abort    <= abort;
            if (accept) begin
                uart_tx_byte <= req_byte[{accept_idx, 3'b000} +: 8];
                last_flag    <= req_last[accept_idx];
                grant        <= NUM_REQ'(1) << accept_idx;
                owner        <= accept_idx;
                stall_cnt    <= '0;
            end else if (abort) begin
                grant     <= '0;
                rr_ptr    <= wrap_add(owner, 1);
                stall_cnt <= '0;
            end else if (stall_inc) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (release_lock) begin
                grant  <= '0;
                rr_ptr <= wrap_add(owner, 1);
            end
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter among NUM_REQ on-board requesters, such as telemetry, motor status and debug. Each requester offers bytes over a valid/ready handshake. The arbiter grants the transmitter round-robin and locks the grant for a whole multi-byte message, so messages never interleave on the serial line. It drives the UART's `transmit`/`tx_byte` inputs and paces itself from the UART's `is_transmitting` output.

## Interface
- NUM_REQ, 3, number of requesters (2..4)
- LOCK_TIMEOUT, 50000, idle cycles a locked owner may stall before its lock is revoked (1 ms at 50 MHz); 16-bit compare
- clk  in  1  master clock (50 MHz)
- rst  in  1  reset, asynchronous, active-low (all state cleared while low)
- req_valid  in  NUM_REQ  requester i has a byte on its lane
- req_byte  in  8*NUM_REQ  lane i at [8*i+7:8*i]
- req_last  in  NUM_REQ  byte on lane i ends its message (releases lock)
- req_ready  out  NUM_REQ  one-hot; byte on lane i accepted this cycle when req_valid[i] & req_ready[i]
- grant  out  NUM_REQ  one-hot owner of the current lock; 0 when unlocked
- uart_transmit  out  1  one-cycle pulse to UART `transmit`
- uart_tx_byte  out  8  byte to UART `tx_byte`, held stable from pulse until next accept
- uart_is_transmitting  in  1  UART `is_transmitting`
- busy  out  1  high in any state other than IDLE, or while a lock is held
- lock_abort  out  1  one-cycle pulse when a lock is revoked by timeout

## Operation
- State machine: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE (2-bit).
- IDLE, unlocked:
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; first valid lane i wins.
  - req_ready[i] is asserted combinationally in the same cycle.
  - On acceptance, latch req_byte lane i into uart_tx_byte and latch req_last[i] into last_flag.
  - Set grant to one-hot i and go to ISSUE.
- IDLE, locked to owner i:
  - Only lane i is considered; other valids are ignored and see req_ready=0.
  - If req_valid[i]=1: accept as above and clear stall_cnt.
  - If req_valid[i]=0: stall_cnt increments. When stall_cnt reaches LOCK_TIMEOUT-1:
    - clear grant, pulse lock_abort, set rr_ptr=(i+1) mod NUM_REQ, clear stall_cnt;
    - stay in IDLE, with arbitration resuming next cycle.
- ISSUE: uart_transmit=1 for exactly this cycle, then go to WAIT_BUSY.
- WAIT_BUSY: remain until uart_is_transmitting=1, then go to WAIT_DONE.
- WAIT_DONE: remain until uart_is_transmitting=0, then:
  - if last_flag: clear grant and set rr_ptr=(owner+1) mod NUM_REQ;
  - otherwise the lock is retained.
  - Go to IDLE in both cases.
- A single-byte message is a byte with req_last=1. It locks and releases within one pass.
- rr_ptr advances only on message completion or abort, never per byte.
- Reset (rst low, any state, including mid-transmission):
  - state=IDLE, grant=0, rr_ptr=0, stall_cnt=0, uart_tx_byte=0, last_flag=0;
  - uart_transmit=0, lock_abort=0, req_ready=0, busy=0.
  - A UART frame already in flight is not aborted by this block. After reset, arbitration waits in IDLE, and an accept cannot start until uart_is_transmitting=0.

## Timing
- Accept (valid&ready) at cycle T; uart_transmit pulse at T+1.
- UART raises is_transmitting at T+2. WAIT_DONE is entered at T+3 and lasts for the frame.
- Earliest next accept is the cycle after the UART's is_transmitting falls plus one (IDLE re-entry).
- uart_transmit, lock_abort, grant and uart_tx_byte are registered. req_ready is combinational from state, grant, rr_ptr and req_valid, with no combinational path from req_byte.
- In IDLE, accept is gated by uart_is_transmitting=0.
- Simultaneous events:
  - Timeout expiry and req_valid[owner] rising in the same cycle: the accept wins and there is no abort.
  - Several valids when unlocked: the round-robin order from rr_ptr decides.
- Byte throughput is bounded by the UART frame time (≈1.04 ms at 9600 baud). The arbiter adds 2 cycles of overhead per byte.

## Test plan
- Single requester:
  - Stimulus: lane0 sends 0x55 with last=1.
  - Response: req_ready[0] pulses once, uart_transmit pulses one cycle later with uart_tx_byte=0x55, grant returns to 0 after is_transmitting falls, rr_ptr=1.
- Contention:
  - Stimulus: lanes 0, 1, 2 all valid with single-byte messages 0xA0, 0xA1, 0xA2.
  - Response: serial output order is A0, A1, A2; next round starting at lane 0 again.
- Locked message:
  - Stimulus: lane1 sends 0x10, 0x11, 0x12 (last on 0x12) while lane0 is continuously valid with 0xEE.
  - Response: 10, 11, 12 are transmitted contiguously; 0xEE follows only after the lock is released.
- Lock timeout (LOCK_TIMEOUT=20):
  - Stimulus: lane2 sends 0x30 with last=0, then drops valid; lane0 is valid.
  - Response: lock_abort pulses exactly 20 idle cycles after IDLE re-entry; lane0 is granted next.
- Reset mid-frame:
  - Stimulus: assert rst low during WAIT_DONE.
  - Response: all outputs are 0 immediately (asynchronous); after release, the arbiter waits for is_transmitting=0 before the next accept; rr_ptr=0.
